// File: rtl/avalon_host_dma.sv
// Avalon-MM block-transfer host: writes incrementing bytes or reads a block
// back with a running sum, one transaction per cycle, checking every response.
module avalon_host_dma #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [7:0]        seed,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic [15:0]       sum,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_read,
  output logic              av_write,
  output logic [7:0]        av_writedata,
  input  logic [7:0]        av_readdata,
  input  logic [1:0]        av_response
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              chk_q, chk_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [15:0]       sum_q, sum_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    sum_d      = sum_q;
    // Response of the request seen on the bus last cycle arrives now.
    chk_d      = rd_q | wr_q;
    chk_addr_d = addr_q;

    if (chk_q) begin
      if (av_response != 2'b00 && !err_q) begin
        err_d      = 1'b1;
        err_addr_d = chk_addr_q;
      end
      if (op_q) begin
        rd_valid_d = 1'b1;
        rd_data_d  = av_readdata;
        sum_d      = sum_q + 16'(av_readdata);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (start) begin
          err_d  = 1'b0;
          sum_d  = 16'h0;
          busy_d = 1'b1;
          if (length != '0) begin
            op_d       = op;
            err_addr_d = '0;
            addr_d     = base_addr;
            wdata_d    = seed;
            cnt_d      = length - LEN_W'(1);
            rd_d       = op;
            wr_d       = !op;
            state_d    = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_DRAIN;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          wdata_d = wdata_q + 8'd1;
          cnt_d   = cnt_q - LEN_W'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= 8'h0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      chk_q      <= 1'b0;
      chk_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h0;
      sum_q      <= 16'h0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      chk_q      <= chk_d;
      chk_addr_q <= chk_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      sum_q      <= sum_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_addr     = err_addr_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign sum          = sum_q;
  assign av_address   = addr_q;
  assign av_read      = rd_q;
  assign av_write     = wr_q;
  assign av_writedata = wdata_q;

endmodule

// File: tb/tb_avalon_host_dma.sv
// Bench for avalon_host_dma: byte-memory agent plus a per-command
// reference model of bus traffic, read data, sum, errors and timing.
module tb_avalon_host_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic [7:0]  seed;
  logic        busy, done, err, rd_valid;
  logic [9:0]  err_addr, av_address;
  logic [7:0]  rd_data, av_writedata;
  logic [15:0] sum;
  logic        av_read, av_write;
  logic [7:0]  av_readdata;
  logic [1:0]  av_response;

  avalon_host_dma dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .base_addr(base_addr), .length(length), .seed(seed),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .sum(sum),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_response(av_response)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Agent: byte RAM, registered readdata/response, SLVERR when idle.
  logic [7:0] mem    [1024];
  logic [7:0] refmem [1024];
  logic       force_en   = 1'b0;
  logic [9:0] force_addr = '0;

  always @(posedge clk) begin
    if (av_write) mem[av_address] = av_writedata;
    av_readdata <= mem[av_address];
    if (av_read || av_write)
      av_response <= (force_en && av_address == force_addr) ? 2'b10 : 2'b00;
    else
      av_response <= 2'b10;
  end

  // Bus / output monitor.
  logic [9:0] tq_addr [$];
  logic       tq_we   [$];
  logic [7:0] tq_data [$];
  int         tq_cyc  [$];
  logic [7:0] rq_data [$];
  int         rq_cyc  [$];
  int         dq_cyc  [$];
  int         busy_cnt = 0;
  int         both_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (av_read || av_write) begin
        tq_addr.push_back(av_address);
        tq_we.push_back(av_write);
        tq_data.push_back(av_writedata);
        tq_cyc.push_back(cyc);
      end
      if (av_read && av_write) both_cnt++;
      if (rd_valid) begin
        rq_data.push_back(rd_data);
        rq_cyc.push_back(cyc);
      end
      if (done) dq_cyc.push_back(cyc);
      if (busy) busy_cnt++;
    end
  end

  task automatic clear_mon();
    tq_addr.delete(); tq_we.delete(); tq_data.delete(); tq_cyc.delete();
    rq_data.delete(); rq_cyc.delete(); dq_cyc.delete();
    busy_cnt = 0;
  endtask

  // Runs one command and verifies it against the reference model.
  task automatic run_cmd(input logic o, input logic [9:0] b,
                         input logic [10:0] l, input logic [7:0] s,
                         input logic poke, input string nm);
    logic [7:0]  exp_rd [$];
    logic [15:0] esum;
    logic        eerr;
    logic [9:0]  eaddr;
    logic [9:0]  a;
    int          scyc;
    int          elat;
    esum  = 16'h0;
    eerr  = 1'b0;
    eaddr = '0;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 10'(i);
      if (force_en && a == force_addr && !eerr) begin
        eerr  = 1'b1;
        eaddr = a;
      end
      if (o) begin
        exp_rd.push_back(refmem[a]);
        esum = esum + 16'(refmem[a]);
      end else begin
        refmem[a] = s + 8'(i);
      end
    end
    elat = (l == 0) ? 1 : int'(l) + 2;

    clear_mon();
    @(negedge clk);
    op = o; base_addr = b; length = l; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scyc  = cyc;
    if (poke) begin
      @(negedge clk);
      start = 1'b1; op = ~o; length = 11'd7;
      base_addr = b + 10'd100; seed = ~s;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (int'(l) + 6) @(negedge clk);

    n_total++;
    if (dq_cyc.size() !== 1)
      $display("FAIL %s done_count: got %0d want 1", nm, dq_cyc.size());
    else begin
      n_pass++;
      n_total++;
      if (dq_cyc[0] - scyc !== elat)
        $display("FAIL %s done_latency: got %0d want %0d", nm, dq_cyc[0] - scyc, elat);
      else n_pass++;
    end
    n_total++;
    if (busy_cnt !== elat)
      $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_cnt, elat);
    else n_pass++;
    n_total++;
    if (tq_addr.size() !== int'(l))
      $display("FAIL %s txn_count: got %0d want %0d", nm, tq_addr.size(), l);
    else begin
      n_pass++;
      for (int i = 0; i < int'(l); i++) begin
        a = b + 10'(i);
        n_total++;
        if (tq_addr[i] !== a || tq_we[i] !== !o || tq_cyc[i] - scyc !== i)
          $display("FAIL %s txn[%0d]: got addr=%h we=%0d cyc=%0d want addr=%h we=%0d cyc=%0d",
                   nm, i, tq_addr[i], tq_we[i], tq_cyc[i] - scyc, a, !o, i);
        else n_pass++;
        if (!o) begin
          n_total++;
          if (tq_data[i] !== s + 8'(i))
            $display("FAIL %s wdata[%0d]: got %h want %h", nm, i, tq_data[i], s + 8'(i));
          else n_pass++;
        end
      end
    end
    n_total++;
    if (rq_data.size() !== exp_rd.size())
      $display("FAIL %s rd_count: got %0d want %0d", nm, rq_data.size(), exp_rd.size());
    else begin
      n_pass++;
      for (int i = 0; i < exp_rd.size(); i++) begin
        n_total++;
        if (rq_data[i] !== exp_rd[i] || rq_cyc[i] - scyc !== i + 2)
          $display("FAIL %s rd[%0d]: got data=%h cyc=%0d want data=%h cyc=%0d",
                   nm, i, rq_data[i], rq_cyc[i] - scyc, exp_rd[i], i + 2);
        else n_pass++;
      end
    end
    n_total++;
    if (sum !== esum)
      $display("FAIL %s sum: got %h want %h", nm, sum, esum);
    else n_pass++;
    n_total++;
    if (err !== eerr)
      $display("FAIL %s err: got %0d want %0d", nm, err, eerr);
    else n_pass++;
    if (l != 0) begin
      n_total++;
      if (err_addr !== eaddr)
        $display("FAIL %s err_addr: got %h want %h", nm, err_addr, eaddr);
      else n_pass++;
    end
    n_total++;
    if (both_cnt !== 0)
      $display("FAIL %s rd_wr_overlap: got %0d want 0", nm, both_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0;
    base_addr = '0; length = '0; seed = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 8'($urandom);
      refmem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, err, rd_valid, av_read, av_write} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy, done, err, rd_valid, av_read, av_write});
    else n_pass++;
    n_total++;
    if (err_addr !== 10'h0 || sum !== 16'h0 || av_address !== 10'h0)
      $display("FAIL reset_data: got err_addr=%h sum=%h addr=%h want 0",
               err_addr, sum, av_address);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] want [4];
    want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_cmd(1'b0, 10'h010, 11'd4, 8'hFE, 1'b0, "write");
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (mem[10'h010 + 10'(i)] !== want[i])
        $display("FAIL write_mem[%0d]: got %h want %h", i, mem[10'h010 + 10'(i)], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_read();
    run_cmd(1'b1, 10'h010, 11'd4, 8'h00, 1'b0, "read");
    n_total++;
    if (sum !== 16'h01FE)
      $display("FAIL read_sum_const: got %h want 01fe", sum);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [9:0] want [4];
    want = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    run_cmd(1'b0, 10'h3FE, 11'd4, 8'h40, 1'b0, "wrap_wr");
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (i >= tq_addr.size() || tq_addr[i] !== want[i])
        $display("FAIL wrap_addr[%0d]: got %h want %h", i,
                 (i < tq_addr.size()) ? tq_addr[i] : 10'h0, want[i]);
      else n_pass++;
    end
    run_cmd(1'b1, 10'h3FE, 11'd4, 8'h00, 1'b0, "wrap_rd");
  endtask

  task automatic test_slverr();
    force_en = 1'b1; force_addr = 10'h021;
    run_cmd(1'b1, 10'h020, 11'd3, 8'h00, 1'b0, "slverr");
    n_total++;
    if (err !== 1'b1 || err_addr !== 10'h021)
      $display("FAIL slverr_const: got err=%0d addr=%h want err=1 addr=021", err, err_addr);
    else n_pass++;
    force_en = 1'b0;
  endtask

  task automatic test_zero_len();
    run_cmd(1'b0, 10'h155, 11'd0, 8'h12, 1'b0, "zero_wr");
    force_en = 1'b1; force_addr = 10'h201;
    run_cmd(1'b1, 10'h200, 11'd2, 8'h00, 1'b0, "pre_zero");
    force_en = 1'b0;
    run_cmd(1'b1, 10'h200, 11'd0, 8'h00, 1'b0, "zero_rd");
  endtask

  task automatic test_busy_start();
    run_cmd(1'b0, 10'($urandom), 11'd8, 8'($urandom), 1'b1, "busy_wr");
    run_cmd(1'b1, 10'($urandom), 11'd6, 8'h00, 1'b1, "busy_rd");
  endtask

  task automatic test_back_to_back();
    logic        o;
    logic [9:0]  b;
    logic [10:0] l;
    for (int k = 0; k < 25; k++) begin
      o = 1'($urandom);
      b = 10'($urandom);
      l = 11'($urandom_range(0, 40));
      force_en   = ($urandom_range(0, 2) == 0);
      force_addr = b + 10'($urandom_range(0, int'(l) + 2));
      run_cmd(o, b, l, 8'($urandom), 1'b0, $sformatf("rand%0d", k));
    end
    force_en = 1'b0;
  endtask

  task automatic test_async_reset();
    force_en = 1'b1; force_addr = 10'h302;
    clear_mon();
    @(negedge clk);
    op = 1'b1; base_addr = 10'h300; length = 11'd30; seed = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_total++;
    if (err !== 1'b1 || av_read !== 1'b1)
      $display("FAIL arst_pre: got err=%0d rd=%0d want err=1 rd=1", err, av_read);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({av_read, av_write, busy, done, rd_valid, err} !== 6'b0)
      $display("FAIL arst_ctrl: got %b want 000000",
               {av_read, av_write, busy, done, rd_valid, err});
    else n_pass++;
    n_total++;
    if (sum !== 16'h0 || err_addr !== 10'h0)
      $display("FAIL arst_data: got sum=%h err_addr=%h want 0", sum, err_addr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    repeat (40) @(negedge clk);
    n_total++;
    if (dq_cyc.size() !== 0 || tq_addr.size() !== 0 || busy_cnt !== 0)
      $display("FAIL arst_quiet: got done=%0d txn=%0d busy=%0d want 0",
               dq_cyc.size(), tq_addr.size(), busy_cnt);
    else n_pass++;
    n_total++;
    if (err !== 1'b0)
      $display("FAIL arst_err: got %0d want 0", err);
    else n_pass++;
    force_en = 1'b0;
    run_cmd(1'b1, 10'h300, 11'd5, 8'h00, 1'b0, "post_arst");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_slverr();
    test_zero_len();
    test_busy_start();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
